// File: rtl/data_ram_pkg.sv
// Shared constants for the CPU data-memory path.
// The front-end address decoder uses the same byte limit as the RAM, so both
// blocks agree on which addresses raise an access fault.
package data_ram_pkg;

    localparam int unsigned DEPTH_WORDS = 3072;
    localparam int unsigned ADDR_W      = 14;
    localparam int unsigned WORD_IDX_W  = ADDR_W - 2;
    localparam int unsigned DATA_W      = 32;

    // First byte address past the end of data memory (3072 words * 4 bytes).
    localparam logic [ADDR_W-1:0] DMEM_BYTE_LIMIT = 14'h3000;

    // True when a byte address falls inside data memory. The limit is word
    // aligned, so comparing the full byte address is the same as comparing
    // the word index against DEPTH_WORDS.
    function automatic logic isInRange(input logic [ADDR_W-1:0] byteAddr);
        return byteAddr < DMEM_BYTE_LIMIT;
    endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM behind the CPU data-memory front end.
// Asynchronous zero-latency read, synchronous write, asynchronous clear.
// There is no handshake: one access may be presented every cycle, the read
// word is valid combinationally in the same cycle, and a write commits on
// the next rising clock edge. A read and write to the same word in one cycle
// sees the old value until the edge (no bypass), which keeps the front end's
// read-modify-write merge consistent.
module data_ram
    import data_ram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              readEnable,
    input  logic              writeEnable,
    input  logic [DATA_W-1:0] writeDataIn,
    output logic [DATA_W-1:0] readData,
    output logic              exception
);

    logic [DATA_W-1:0]     mem [0:DEPTH_WORDS-1];
    logic [WORD_IDX_W-1:0] wordIdx;
    logic                  inRange;

    // Byte offset bits are dropped; alignment is enforced upstream.
    assign wordIdx = address[ADDR_W-1:2];
    assign inRange = isInRange(address);

    // Storage update: reset clears every word, otherwise in-range writes commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (writeEnable && inRange) begin
            mem[wordIdx] <= writeDataIn;
        end
    end

    // Combinational read word and access-fault flag.
    always_comb begin
        readData  = '0;
        exception = (readEnable | writeEnable) & ~inRange;
        if (!reset && readEnable && inRange) begin
            readData = mem[wordIdx];
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: directed scenarios plus a randomized
// phase, all checked against a plain word-array model of the memory.
module tb_data_ram;

    logic        clk;
    logic        reset;
    logic [13:0] address;
    logic        readEnable;
    logic        writeEnable;
    logic [31:0] writeDataIn;
    logic [31:0] readData;
    logic        exception;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference memory: 3072 words, byte range 0x0000..0x2FFF.
    logic [31:0] model [0:3071];
    logic [31:0] exp_q [$];

    data_ram dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .readEnable (readEnable),
        .writeEnable(writeEnable),
        .writeDataIn(writeDataIn),
        .readData   (readData),
        .exception  (exception)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 3072; i++) model[i] = 32'h0;
    endfunction

    // Expected read word straight from the behavioural rules.
    function automatic logic [31:0] model_read(input int a, input bit re, input bit rst);
        if (rst || !re || a >= 'h3000) return 32'h0;
        return model[a / 4];
    endfunction

    function automatic logic [31:0] model_exc(input int a, input bit re, input bit we);
        return {31'h0, (re || we) && (a >= 'h3000)};
    endfunction

    // Scoreboard: queue the expectations for the currently presented access,
    // then compare the DUT outputs against them in order.
    task automatic check_now(input string tag);
        int a;
        a = int'(address);
        exp_q.push_back(model_read(a, readEnable, reset));
        exp_q.push_back(model_exc(a, readEnable, writeEnable));
        check({tag, ".rd"}, readData, exp_q.pop_front());
        check({tag, ".exc"}, {31'h0, exception}, exp_q.pop_front());
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [13:0] a, input bit re, input bit we, input logic [31:0] d);
        @(negedge clk);
        address     = a;
        readEnable  = re;
        writeEnable = we;
        writeDataIn = d;
        #1;
    endtask

    // Advance through the rising edge and let the model commit the write.
    task automatic tick();
        int a;
        @(posedge clk);
        a = int'(address);
        if (writeEnable && !reset && a < 'h3000) model[a / 4] = writeDataIn;
        #1;
    endtask

    task automatic write_word(input logic [13:0] a, input logic [31:0] d);
        drive(a, 1'b0, 1'b1, d);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        address     = '0;
        readEnable  = 1'b0;
        writeEnable = 1'b0;
        writeDataIn = '0;
        model_clear();

        // Write coincident with reset must be ignored; reads give 0 in reset.
        drive(14'h0000, 1'b1, 1'b1, 32'hFFFF_FFFF);
        check_now("rst_wr");
        check("rst_rd_zero", readData, 32'h0);
        tick();
        reset = 1'b0;
        drive(14'h0000, 1'b1, 1'b0, 32'h0);
        check("rst_wr_dropped", readData, 32'h0);

        // Reset clear: a mid-cycle reset pulse zeroes storage at once.
        write_word(14'h0010, 32'hDEAD_BEEF);
        drive(14'h0010, 1'b1, 1'b0, 32'h0);
        check("pre_rst", readData, 32'hDEAD_BEEF);
        reset = 1'b1;
        model_clear();
        #1;
        check("in_rst", readData, 32'h0);
        reset = 1'b0;
        #1;
        check_now("post_rst");
        tick();

        // Basic write/read, byte offsets ignored.
        write_word(14'h0004, 32'h1234_5678);
        drive(14'h0004, 1'b1, 1'b0, 32'h0);
        check("rd_0004", readData, 32'h1234_5678);
        drive(14'h0005, 1'b1, 1'b0, 32'h0);
        check("rd_0005", readData, 32'h1234_5678);
        drive(14'h0007, 1'b1, 1'b0, 32'h0);
        check("rd_0007", readData, 32'h1234_5678);

        // Read-before-write on the same word.
        write_word(14'h0008, 32'hAAAA_AAAA);
        drive(14'h0008, 1'b1, 1'b1, 32'h5555_5555);
        check("rbw_old", readData, 32'hAAAA_AAAA);
        tick();
        check("rbw_new", readData, 32'h5555_5555);

        // Boundary.
        drive(14'h2FFC, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("top_wr_exc", {31'h0, exception}, 32'h0);
        tick();
        drive(14'h2FFC, 1'b1, 1'b0, 32'h0);
        check("top_rd", readData, 32'hCAFE_F00D);
        drive(14'h3000, 1'b1, 1'b1, 32'h0BAD_0BAD);
        check("oor_exc", {31'h0, exception}, 32'h1);
        check("oor_rd", readData, 32'h0);
        tick();
        drive(14'h2FFC, 1'b1, 1'b0, 32'h0);
        check("oor_wr_dropped", readData, 32'hCAFE_F00D);
        drive(14'h0000, 1'b1, 1'b0, 32'h0);
        check("oor_no_alias", readData, 32'h0);
        drive(14'h3FFC, 1'b1, 1'b0, 32'h0);
        check("max_exc", {31'h0, exception}, 32'h1);

        // Enables.
        drive(14'h3000, 1'b0, 1'b0, 32'h0);
        check("idle_exc", {31'h0, exception}, 32'h0);
        check("idle_rd", readData, 32'h0);
        drive(14'h0004, 1'b0, 1'b0, 32'h0);
        check("re_off", readData, 32'h0);

        // Back-to-back writes on consecutive cycles.
        write_word(14'h000C, 32'h0);
        write_word(14'h0000, 32'h1);
        write_word(14'h0004, 32'h2);
        write_word(14'h0008, 32'h3);
        drive(14'h0000, 1'b1, 1'b0, 32'h0); check("b2b_0", readData, 32'h1);
        drive(14'h0004, 1'b1, 1'b0, 32'h0); check("b2b_1", readData, 32'h2);
        drive(14'h0008, 1'b1, 1'b0, 32'h0); check("b2b_2", readData, 32'h3);
        drive(14'h000C, 1'b1, 1'b0, 32'h0); check("b2b_nb", readData, 32'h0);
        drive(14'h0010, 1'b1, 1'b0, 32'h0); check("b2b_nb2", readData, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [13:0] a;
            case ($urandom_range(0, 9))
                0:       a = 14'($urandom_range('h3000, 'h3FFF));
                1, 2:    a = 14'($urandom_range(0, 'h2FFF));
                default: a = 14'($urandom_range(0, 63));
            endcase
            drive(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            check_now("rand");
            tick();
        end

        // Final sweep of the low window read back against the model.
        for (int w = 0; w < 16; w++) begin
            drive(14'(w * 4), 1'b1, 1'b0, 32'h0);
            check_now("sweep");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
